// File: rtl/sig_pattern_gen_pkg.sv
// Shared types and constants for the cycle-accurate signal pattern generator.
package sig_gen_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam int unsigned HOLD_MIN = 1;

endpackage

// File: rtl/sig_pattern_gen_cmd_fifo.sv
// First-word fall-through command FIFO; pointers carry one extra wrap bit.
module sig_cmd_fifo #(
   parameter int unsigned DW    = 9,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [DW-1:0]            i_din,
   input  logic                     i_pop,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level,
   output logic [DW-1:0]            o_head
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [PW-1:0] r_wr;
   logic [PW-1:0] r_rd;
   logic [DW-1:0] r_mem [DEPTH];
   logic          w_push;
   logic          w_pop;

   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_empty = (r_wr == r_rd);
   assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign o_level = r_wr - r_rd;
   assign o_head  = r_mem[r_rd[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + PW'(1);
         if (w_pop)  r_rd <= r_rd + PW'(1);
      end
   end

   // Storage needs no reset: empty pointers hide stale contents.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr[AW-1:0]] <= i_din;
   end

endmodule

// File: rtl/sig_pattern_gen.sv
// Drives sig with commanded (value, hold) pairs; changing flags the next-edge transition.
module sig_pattern_gen
   import sig_gen_pkg::*;
#(
   parameter int unsigned WIDTH  = 1,
   parameter int unsigned HOLD_W = 8,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [WIDTH-1:0]       cmd_value,
   input  logic [HOLD_W-1:0]      cmd_hold,
   output logic [WIDTH-1:0]       sig,
   output logic                   changing,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] level
);

   localparam int unsigned LW = $clog2(DEPTH) + 1;
   localparam int unsigned CW = WIDTH + HOLD_W;

   typedef struct packed {
      logic [WIDTH-1:0]  value;
      logic [HOLD_W-1:0] hold;
   } cmd_t;

   cmd_t              w_in;
   cmd_t              w_head;
   logic              w_push;
   logic              w_ld;
   logic              w_full;
   logic              w_empty;
   logic [LW-1:0]     w_level;
   logic [HOLD_W-1:0] w_cnt_ld;

   state_t            r_state;
   logic [HOLD_W-1:0] r_cnt;
   logic [WIDTH-1:0]  r_sig;

   assign w_in.value = cmd_value;
   assign w_in.hold  = cmd_hold;
   assign cmd_ready  = !w_full;
   assign w_push     = cmd_valid && cmd_ready;

   sig_cmd_fifo #(
      .DW    (CW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_din   (w_in),
      .i_pop   (w_ld),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (w_level),
      .o_head  (w_head)
   );

   // A hold of 0 behaves like HOLD_MIN; counter holds remaining cycles minus one.
   assign w_cnt_ld = (w_head.hold > HOLD_W'(HOLD_MIN)) ?
                     (w_head.hold - HOLD_W'(HOLD_MIN)) : '0;

   assign w_ld = ((r_state == IDLE) || ((r_state == HOLD) && (r_cnt == '0))) && !w_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_sig   <= '0;
      end else if (w_ld) begin
         r_state <= HOLD;
         r_cnt   <= w_cnt_ld;
         r_sig   <= w_head.value;
      end else if (r_state == HOLD) begin
         if (r_cnt != '0) r_cnt   <= r_cnt - HOLD_W'(1);
         else             r_state <= IDLE;
      end
   end

   assign changing = w_ld && (w_head.value != r_sig);
   assign busy     = ((r_state == HOLD) && !((r_cnt == '0) && w_empty)) || (w_level != '0);
   assign sig      = r_sig;
   assign level    = w_level;

endmodule

// File: tb/tb_sig_pattern_gen.sv
// Randomized scoreboard bench: stimulus predicts load timeline, monitor checks every cycle.
module tb_sig_pattern_gen;

   localparam int unsigned TW    = 1;
   localparam int unsigned HW    = 8;
   localparam int unsigned DEPTH = 4;

   logic                   clk;
   logic                   rst;
   logic                   cmd_valid;
   logic                   cmd_ready;
   logic [TW-1:0]          cmd_value;
   logic [HW-1:0]          cmd_hold;
   logic [TW-1:0]          sig;
   logic                   changing;
   logic                   busy;
   logic [$clog2(DEPTH):0] level;

   sig_pattern_gen #(.WIDTH(TW), .HOLD_W(HW), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_value (cmd_value),
      .cmd_hold  (cmd_hold),
      .sig       (sig),
      .changing  (changing),
      .busy      (busy),
      .level     (level)
   );

   // One accepted command: edge at which it loads, edge at which its hold ends, value.
   typedef struct {
      int            le;
      int            en;
      logic [TW-1:0] val;
   } ld_t;

   ld_t           exp_q[$];
   int            cyc = 0;
   int            n_checks = 0;
   int            n_err = 0;
   int            t_free = 0;
   logic [TW-1:0] cur_val = '0;
   int            cur_end = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, got, exp);
      end
   endtask

   // Offer one command until accepted; record its predicted load slot.
   task automatic send(input int v, input int h);
      int   waitc;
      bit   done;
      logic rdy;
      int   k;
      int   le;
      int   hh;
      waitc     = 0;
      done      = 1'b0;
      cmd_valid = 1'b1;
      cmd_value = TW'(v);
      cmd_hold  = HW'(h);
      while (!done) begin
         @(negedge clk);
         rdy = cmd_ready;
         k   = cyc + 1;
         @(posedge clk);
         if (rdy) begin
            hh     = (h == 0) ? 1 : h;
            le     = (k + 1 > t_free) ? k + 1 : t_free;
            t_free = le + hh;
            exp_q.push_back('{le: le, en: le + hh, val: TW'(v)});
            done   = 1'b1;
         end else begin
            waitc++;
            if (waitc > 1000) begin
               n_checks++;
               n_err++;
               $display("FAIL accept_timeout at cycle %0d: got no ready expected ready within 1000", cyc);
               done = 1'b1;
            end
         end
         #1;
      end
      cmd_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      #2;
      rst    = 1'b1;
      t_free = 0;
      repeat (n) @(posedge clk);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops the scoreboard at each load edge and checks all outputs.
   initial begin
      int  n;
      int  lvl;
      bit  chg;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            exp_q.delete();
            cur_val = '0;
            cur_end = 0;
         end
         n = cyc;
         if (exp_q.size() > 0 && exp_q[0].le == n) begin
            cur_val = exp_q[0].val;
            cur_end = exp_q[0].en;
            void'(exp_q.pop_front());
         end
         lvl = exp_q.size();
         chg = (exp_q.size() > 0) && (exp_q[0].le == n + 1) && (exp_q[0].val != cur_val);
         chk("sig",       int'(sig),       int'(cur_val));
         chk("level",     int'(level),     lvl);
         chk("cmd_ready", int'(cmd_ready), int'(lvl != int'(DEPTH)));
         chk("busy",      int'(busy),      int'((n < cur_end - 1) || (lvl != 0)));
         chk("changing",  int'(changing),  int'(chg));
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog at cycle %0d: got no finish expected finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int v;
      int h;
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_value = '0;
      cmd_hold  = '0;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      idle(10);

      send(1, 3);
      idle(8);

      do_reset(2);
      send(1, 2); send(0, 1); send(0, 4); send(1, 0);
      idle(12);

      do_reset(2);
      send(1, 200);
      send(0, 1); send(1, 2); send(0, 1); send(1, 1);
      send(0, 3);
      idle(15);

      do_reset(2);
      send(0, 3); send(1, 5); send(1, 2); send(1, 3); send(1, 1);
      @(posedge clk);
      #3;
      rst    = 1'b1;
      t_free = 0;
      #1;
      chk("async_rst_sig",   int'(sig),       0);
      chk("async_rst_level", int'(level),     0);
      chk("async_rst_busy",  int'(busy),      0);
      chk("async_rst_ready", int'(cmd_ready), 1);
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      idle(20);

      for (int i = 0; i < 400; i++) begin
         v = int'($urandom_range(0, 1));
         h = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 5));
         send(v, h);
         if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 8)));
      end
      idle(40);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/sig_pattern_gen.md
Name: sig_pattern_gen

Overview:
- Cycle-accurate stimulus generator; the driving end of the sampled-value/global-clocking assertion checkers.
- Accepts (value, hold) commands over a valid/ready handshake and buffers them in a small FIFO.
- Drives `sig`, holding each value stable for exactly the commanded number of `clk` cycles.
- Emits `changing`, a one-cycle-ahead flag with `$changing_gclk` semantics, so benches can cross-check assertion results against ground truth.

Parameters:
- WIDTH, 1: width of `sig` and `cmd_value`.
- HOLD_W, 8: width of `cmd_hold`; maximum hold is 2^HOLD_W-1 cycles.
- DEPTH, 4: command FIFO entries; must be a power of two, >=2.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  FIFO can accept; a transfer occurs when cmd_valid && cmd_ready at posedge.
- cmd_value  input  WIDTH  value to drive on `sig`.
- cmd_hold  input  HOLD_W  cycles to hold the value; 0 is treated as 1.
- sig  output  WIDTH  driven pattern, registered.
- changing  output  1  1 in cycle t iff sig(t+1) != sig(t).
- busy  output  1  1 while a hold is in progress or the FIFO is non-empty.
- level  output  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async assert, sync release):
  - sig=0, cnt=0, state=IDLE, FIFO empty, level=0.
  - cmd_ready=1, changing=0, busy=0.
- cmd_ready = (level != DEPTH). It is not combinationally dependent on cmd_valid, and there is no bypass.
- A push at full is impossible because ready=0.
- Simultaneous push and pop: level unchanged; ordering preserved.
- States: IDLE and HOLD; cnt is a HOLD_W-bit down-counter.
- Load condition `ld` = (state==IDLE || (state==HOLD && cnt==0)) && FIFO non-empty.
- On `ld` at edge e:
  - pop the head;
  - sig <= head.value;
  - cnt <= max(head.hold,1)-1;
  - state <= HOLD.
- HOLD with cnt>0: cnt decrements by 1; sig is stable.
- HOLD with cnt==0 and FIFO empty: state <= IDLE. sig keeps its last value indefinitely; there is no return to 0.
- Hold guarantee: a value loaded at edge e stays on sig for exactly H=max(hold,1) cycles when the FIFO is fed back-to-back. The next load occurs at edge e+H.
- Latency: a command accepted at edge k into an empty, idle block loads at edge k+1. sig shows the new value after edge k+1.
- `changing` is combinational: changing = ld && (head.value != sig).
  - A consecutive command with an equal value gives changing=0 and a seamless extension of the hold.
- busy = (state==HOLD && !(cnt==0 && FIFO empty)) || level!=0.
- cnt arithmetic is unsigned with no wrap, because cnt never decrements below 0.
- Reset mid-hold: everything returns to reset values immediately. Buffered commands are discarded and sig drops to 0 asynchronously.

Decomposition:
- Package `sig_gen_pkg`:
  - `typedef enum logic {IDLE, HOLD} state_t`.
  - Parameterised `cmd_t` struct {value, hold} provided via a localparam-sized typedef in the module.
  - Constant `HOLD_MIN=1`.
- Sub-module `sig_cmd_fifo`:
  - Synchronous FIFO, DEPTH x (WIDTH+HOLD_W).
  - Ports: push, pop, full, empty, level, head (first-word fall-through).
  - Asynchronous active-high rst.
  - Pointers are $clog2(DEPTH)+1 bits; wrap is detected by MSB.
- Top level: FSM, counter and the `changing` logic.

Test Plan:
- Reset then idle: rst=1 for 3 cycles, then 0 with no commands -> sig=0, changing=0, busy=0, cmd_ready=1, level=0 for 10 cycles.
- Single command (value=1, hold=3) accepted at edge k:
  - sig=1 for edges k+1..k+3+ (held) with busy=1.
  - changing=1 only in the cycle before edge k+1.
  - state returns to IDLE after edge k+4; sig stays 1.
- Back-to-back commands (1,2), (0,1), (0,4), (1,0), with WIDTH=1:
  - sig sequence 1,1,0,0,0,0,0,1.
  - changing pulses exactly before each 1->0 and 0->1 transition, and not at the 0->0 boundary.
  - hold=0 is driven for exactly 1 cycle.
- FIFO full with DEPTH=4: during a hold of 200, push 4 commands -> level=4, cmd_ready=0, and the 5th valid is stalled. On the first pop, cmd_ready=1 in the next cycle and the stalled command is accepted; order is preserved.
- Simultaneous push and pop at level=2 -> level stays 2 and the popped value is the oldest.
- Reset mid-hold: assert rst asynchronously (between edges) during the 2nd cycle of a hold of 5 with 3 entries queued -> sig=0 and level=0 immediately; after release no queued value ever appears on sig.
